stream_out_matrix_ping_pong_hs: RTL and testbench
=================================================

// Module: stream_out_matrix_ping_pong_hs
// PURPOSE
//  Parallel-to-serial matrix streamer feeding the turbo decoder's soft-input port.
//  Captures a full R x C matrix of BITS-wide words in one cycle into one of two banks (ping-pong).
//  Streams the matrix out LANES words per beat under valid/ready backpressure.
//  Adds a runtime row/column-major scan order, first/last framing and overflow reporting.
// PARAMETERS
//  BITS   32  width of one matrix element
//  R      3   matrix rows (channel streams: systematic + parities)
//  C      10  matrix columns (N + TAIL_BITS)
//  LANES  1   elements emitted per output beat; R*C % LANES == 0 (elaboration $error otherwise)
//  CNT_W  16  width of the saturating overflow counter
// PORTS
//  clk        in   1             rising-edge clock
//  reset_n    in   1             asynchronous, active-low reset
//  in_valid   in   1             capture request for a/col_major this cycle
//  col_major  in   1             scan order for this matrix: 0=row-major, 1=column-major
//  a          in   BITS*R*C      matrix a[R][C], unpacked [R][C] of [BITS-1:0]
//  in_ready   out  1             a bank can accept a matrix this cycle
//  out_valid  out  1             c holds a valid beat
//  out_ready  in   1             downstream accepts beat
//  c          out  BITS*LANES    c[LANES]; c[0] is earliest element in scan order
//  out_first  out  1             beat is first of a matrix
//  out_last   out  1             beat is last of a matrix
//  overflow   out  1             one-cycle pulse: in_valid while !in_ready, matrix dropped
//  ovf_count  out  CNT_W         saturating count of dropped matrices
// BEHAVIOUR
//  Reset (async assert, sync release): both banks EMPTY, wr_bank=rd_bank=0, beat idx=0;
//   out_valid=0, out_first=0, out_last=0, c=0, overflow=0, ovf_count=0, in_ready=1.
//  Bank state per bank: EMPTY -> FULL (capture) -> EMPTY (last beat handshake). Order = capture order.
//  in_ready = (count<2) | (count==2 & out_valid & out_ready & out_last) -- bank freed this edge
//   is rewritable same edge. Combinational from state and out_ready only.
//  Capture: in_valid & in_ready -> a and col_major latched into bank wr_bank; wr_bank toggles.
//  Drop: in_valid & !in_ready -> no state change, overflow=1 next cycle, ovf_count+1 (saturates).
//  Output: out_valid=1 whenever bank rd_bank FULL. Latency: capture edge t -> out_valid high
//   after t if rd_bank was idle (first beat visible cycle after capture).
//  Beat k (k=0..R*C/LANES-1): lane j = element e=k*LANES+j; row-major a[e/C][e%C],
//   column-major a[e%R][e/R] (per bank's latched col_major).
//  Handshake: beat advances only on out_valid & out_ready; c/out_first/out_last stable while stalled.
//  out_first = (k==0); out_last = (k==R*C/LANES-1); both high if single beat.
//  Last-beat handshake: bank -> EMPTY, rd_bank toggles, k=0; if other bank FULL, its first beat
//   is presented the very next cycle (no bubble between matrices).
//  c driven from registered index via mux; all outputs glitch-free relative to clk.
//  Simultaneous capture and drain of different banks: both take effect same edge.
//  Reset mid-stream: partial matrix discarded, no out_last emitted, outputs to reset values.
//  in_valid ignored (no capture, no overflow) while reset_n=0.
// TESTING
//  1 R=3,C=10,LANES=1, a[r][c]=r*16+c, row-major, out_ready=1 -> 30 beats 0x00..0x09,0x10..,0x29;
//    first on beat 0, last on beat 29, out_valid 1 cycle after capture.
//  2 Same matrix col_major=1 -> sequence 0x00,0x10,0x20,0x01,0x11,...,0x29; last on beat 29.
//  3 LANES=2, row-major -> 15 beats, beat0 c={0x00,0x01}, beat14 c={0x28,0x29}.
//  4 Three back-to-back captures, out_ready=0 -> captures 1,2 accepted, third: in_ready=0,
//    overflow pulse, ovf_count=1; release out_ready -> 60 beats, no gap between matrices.
//  5 Random out_ready (50%) on 2 matrices -> c/flags hold while stalled; scoreboard match, 0 drops.
//  6 Assert reset_n=0 at beat 12 -> out_valid=0 next edge, ovf_count=0; new capture restarts at beat 0.

Source files
------------

// File: rtl/stream_out_matrix_ping_pong_hs.sv
// -----------------------------------------------------------------------------
// stream_out_matrix_ping_pong_hs
//
// Parallel-to-serial matrix streamer for the turbo decoder soft-input port.
// A complete R x C matrix of BITS-wide words is captured in one cycle into one
// of two banks. Captured matrices are then streamed out LANES words per beat
// under valid/ready flow control. Each matrix is scanned in the order that was
// latched with it: row-major or column-major. The beats carry first/last
// framing. A matrix offered while both banks are occupied is dropped, and the
// drop is reported.
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   in_valid   capture request for a / col_major this cycle
//   col_major  scan order of the offered matrix (0 = row-major, 1 = column-major)
//   a          input matrix a[R][C]
//   in_ready   a bank can accept a matrix this cycle
//   out_valid  c holds a valid beat
//   out_ready  downstream accepts the beat
//   c          output beat c[LANES]; c[0] is the earliest element in scan order
//   out_first  beat is the first of a matrix
//   out_last   beat is the last of a matrix
//   overflow   one-cycle pulse after a matrix was dropped
//   ovf_count  saturating count of dropped matrices
// -----------------------------------------------------------------------------
module stream_out_matrix_ping_pong_hs #(
    parameter int BITS  = 32,
    parameter int R     = 3,
    parameter int C     = 10,
    parameter int LANES = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    input  logic             col_major,
    input  logic [BITS-1:0]  a [R][C],
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [BITS-1:0]  c [LANES],
    output logic             out_first,
    output logic             out_last,
    output logic             overflow,
    output logic [CNT_W-1:0] ovf_count
);

    localparam int N     = R * C;
    localparam int BEATS = N / LANES;
    localparam int K_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int E_W   = (N > 1) ? $clog2(N) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(BEATS - 1);

    if (N % LANES != 0) begin : g_lanes_check
        $error("R*C must be a multiple of LANES");
    end

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } bank_st_t;

    bank_st_t         r_st     [2];
    bank_st_t         w_st_nxt [2];
    logic             r_wr;
    logic             r_rd;
    logic [K_W-1:0]   r_k;
    logic             r_ovf;
    logic [CNT_W-1:0] r_cnt;

    // Bank storage is data only and is never reset. Every read of it is
    // qualified by the bank state.
    logic [BITS-1:0]  r_mem [2][N];
    logic             r_cm  [2];

    logic             w_beat;
    logic             w_last_beat;
    logic             w_drain;
    logic             w_cap;
    logic             w_drop;

    // A matrix is stored linearly in row-major order. Scan element e maps to
    // itself in row-major order. In column-major order it maps to row e%R,
    // column e/R.
    function automatic logic [E_W-1:0] addr_of(input int e, input logic cm);
        int lin;
        if (cm)
            lin = (e % R) * C + (e / R);
        else
            lin = e;
        return E_W'(lin);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + CNT_W'(1);
    endfunction

    assign out_valid   = (r_st[r_rd] == FULL);
    assign w_last_beat = (r_k == K_LAST);
    assign w_beat      = out_valid & out_ready;
    assign w_drain     = w_beat & w_last_beat;

    // When both banks are full, the write pointer addresses the bank being
    // read. That bank frees on its last beat and can be refilled on the same
    // edge.
    assign in_ready = (r_st[0] == EMPTY) | (r_st[1] == EMPTY) | w_drain;
    assign w_cap    = in_valid & in_ready;
    assign w_drop   = in_valid & ~in_ready;

    // Per-bank state: a capture into the bank that is draining wins.
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            w_st_nxt[b] = r_st[b];
            if (w_drain && (r_rd == 1'(b)))
                w_st_nxt[b] = EMPTY;
            if (w_cap && (r_wr == 1'(b)))
                w_st_nxt[b] = FULL;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_st[0] <= EMPTY;
            r_st[1] <= EMPTY;
            r_wr    <= 1'b0;
            r_rd    <= 1'b0;
            r_k     <= '0;
            r_ovf   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_st[0] <= w_st_nxt[0];
            r_st[1] <= w_st_nxt[1];
            if (w_cap)
                r_wr <= ~r_wr;
            if (w_beat) begin
                if (w_last_beat) begin
                    r_k  <= '0;
                    r_rd <= ~r_rd;
                end else begin
                    r_k <= r_k + K_W'(1);
                end
            end
            r_ovf <= w_drop;
            if (w_drop)
                r_cnt <= sat_inc(r_cnt);
        end
    end

    always_ff @(posedge clk) begin
        if (w_cap) begin
            r_cm[r_wr] <= col_major;
            for (int r = 0; r < R; r++)
                for (int cc = 0; cc < C; cc++)
                    r_mem[r_wr][E_W'(r * C + cc)] <= a[r][cc];
        end
    end

    // The output mux is driven only from registers. The beat is forced to zero
    // when no beat is valid, so c reads as 0 after reset.
    always_comb begin
        for (int j = 0; j < LANES; j++)
            c[j] = out_valid ? r_mem[r_rd][addr_of(int'(r_k) * LANES + j, r_cm[r_rd])] : '0;
    end

    assign out_first = out_valid & (r_k == '0);
    assign out_last  = out_valid & w_last_beat;
    assign overflow  = r_ovf;
    assign ovf_count = r_cnt;

endmodule

// File: tb/tb_stream_out_matrix_ping_pong_hs.sv
module tb_stream_out_matrix_ping_pong_hs;

    logic        clk;
    logic        reset_n;

    // DUT 0: LANES = 1
    logic        iv0, cm0, ird0, ov0, or0, of0, ol0, ovf0;
    logic [31:0] a0 [3][10];
    logic [31:0] c0 [1];
    logic [15:0] cnt0;

    // DUT 1: LANES = 2
    logic        iv1, cm1, ird1, ov1, or1, of1, ol1, ovf1;
    logic [31:0] a1 [3][10];
    logic [31:0] c1 [2];
    logic [15:0] cnt1;

    int n_vec;
    int n_err;

    stream_out_matrix_ping_pong_hs #(.BITS(32), .R(3), .C(10), .LANES(1), .CNT_W(16)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .in_valid(iv0), .col_major(cm0), .a(a0),
        .in_ready(ird0), .out_valid(ov0), .out_ready(or0), .c(c0),
        .out_first(of0), .out_last(ol0), .overflow(ovf0), .ovf_count(cnt0)
    );

    stream_out_matrix_ping_pong_hs #(.BITS(32), .R(3), .C(10), .LANES(2), .CNT_W(16)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .in_valid(iv1), .col_major(cm1), .a(a1),
        .in_ready(ird1), .out_valid(ov1), .out_ready(or1), .c(c1),
        .out_first(of1), .out_last(ol1), .overflow(ovf1), .ovf_count(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Element e of the test matrix a[r][c] = r*16 + c (R=3, C=10) in scan order.
    function automatic int exp_el(input int e, input bit cm);
        if (cm)
            return (e % 3) * 16 + (e / 3);
        else
            return (e / 10) * 16 + (e % 10);
    endfunction

    task automatic set_a0(input int base);
        for (int r = 0; r < 3; r++)
            for (int cc = 0; cc < 10; cc++)
                a0[r][cc] = 32'(base + r * 16 + cc);
    endtask

    // Entered at a negedge where beat 0 of the first matrix is visible.
    // out_ready is held high, so one beat is consumed every cycle.
    task automatic drain0(input int nb, input int b0, input bit m0, input int b1, input bit m1);
        int e;
        int exp;
        or0 = 1'b1;
        for (int idx = 0; idx < nb; idx++) begin
            iv0 = 1'b0;
            e   = idx % 30;
            exp = (idx < 30) ? b0 + exp_el(e, m0) : b1 + exp_el(e, m1);
            chk("valid", 64'(ov0), 64'd1);
            chk("data",  64'(c0[0]), 64'(exp));
            chk("first", 64'(of0), 64'(e == 0));
            chk("last",  64'(ol0), 64'(e == 29));
            @(negedge clk);
        end
        chk("idle_after", 64'(ov0), 64'd0);
    endtask

    initial begin
        int idx;
        int exp;
        n_vec   = 0;
        n_err   = 0;
        reset_n = 1'b0;
        iv0 = 1'b0; cm0 = 1'b0; or0 = 1'b1;
        iv1 = 1'b0; cm1 = 1'b0; or1 = 1'b1;
        set_a0(0);
        for (int r = 0; r < 3; r++)
            for (int cc = 0; cc < 10; cc++)
                a1[r][cc] = 32'(r * 16 + cc);

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready",  64'(ird0), 64'd1);
        chk("rst_out_valid", 64'(ov0),  64'd0);
        chk("rst_first",     64'(of0),  64'd0);
        chk("rst_last",      64'(ol0),  64'd0);
        chk("rst_c",         64'(c0[0]), 64'd0);
        chk("rst_overflow",  64'(ovf0), 64'd0);
        chk("rst_ovf_count", 64'(cnt0), 64'd0);
        chk("rst_c1_lane1",  64'(c1[1]), 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // 1: row-major, 30 beats, visible one cycle after capture
        set_a0(0); cm0 = 1'b0; iv0 = 1'b1;
        @(negedge clk);
        drain0(30, 0, 1'b0, 0, 1'b0);

        // 2: column-major scan of the same matrix
        set_a0(0); cm0 = 1'b1; iv0 = 1'b1;
        @(negedge clk);
        drain0(30, 0, 1'b1, 0, 1'b0);

        // 3: two lanes, 15 beats
        cm1 = 1'b0; iv1 = 1'b1;
        @(negedge clk);
        iv1 = 1'b0;
        for (int k = 0; k < 15; k++) begin
            chk("l2_valid", 64'(ov1), 64'd1);
            chk("l2_lane0", 64'(c1[0]), 64'(exp_el(2 * k, 1'b0)));
            chk("l2_lane1", 64'(c1[1]), 64'(exp_el(2 * k + 1, 1'b0)));
            chk("l2_first", 64'(of1), 64'(k == 0));
            chk("l2_last",  64'(ol1), 64'(k == 14));
            @(negedge clk);
        end
        chk("l2_idle", 64'(ov1), 64'd0);

        // 4: three captures while stalled; the third is dropped
        or0 = 1'b0;
        set_a0(0); cm0 = 1'b0; iv0 = 1'b1;
        @(negedge clk);
        chk("t4_ready2", 64'(ird0), 64'd1);
        set_a0(32'h100); cm0 = 1'b1;
        @(negedge clk);
        chk("t4_ready3", 64'(ird0), 64'd0);
        chk("t4_valid",  64'(ov0),  64'd1);
        set_a0(32'h200); cm0 = 1'b0;
        @(negedge clk);
        iv0 = 1'b0;
        chk("t4_ovf_pulse", 64'(ovf0), 64'd1);
        chk("t4_ovf_count", 64'(cnt0), 64'd1);
        chk("t4_hold_c",    64'(c0[0]), 64'h0);
        chk("t4_hold_first", 64'(of0), 64'd1);
        @(negedge clk);
        chk("t4_ovf_clear", 64'(ovf0), 64'd0);
        chk("t4_ovf_keep",  64'(cnt0), 64'd1);
        drain0(60, 0, 1'b0, 32'h100, 1'b1);

        // 5: random backpressure over two matrices, the second captured mid-stream
        or0 = 1'b0;
        set_a0(32'h300); cm0 = 1'b0; iv0 = 1'b1;
        @(negedge clk);
        iv0 = 1'b0;
        idx = 0;
        for (int cyc = 0; cyc < 2000 && idx < 60; cyc++) begin
            exp = (idx < 30) ? 32'h300 + exp_el(idx % 30, 1'b0)
                             : 32'h400 + exp_el(idx % 30, 1'b1);
            chk("t5_valid", 64'(ov0), 64'd1);
            chk("t5_data",  64'(c0[0]), 64'(exp));
            chk("t5_first", 64'(of0), 64'((idx % 30) == 0));
            chk("t5_last",  64'(ol0), 64'((idx % 30) == 29));
            or0 = 1'($urandom_range(0, 1));
            if (cyc == 5) begin
                chk("t5_ready", 64'(ird0), 64'd1);
                set_a0(32'h400); cm0 = 1'b1; iv0 = 1'b1;
            end else begin
                iv0 = 1'b0;
            end
            if (ov0 && or0)
                idx++;
            @(negedge clk);
        end
        iv0 = 1'b0;
        chk("t5_done",      64'(idx),  64'd60);
        chk("t5_no_drop",   64'(cnt0), 64'd1);
        chk("t5_idle",      64'(ov0),  64'd0);

        // 6: reset mid-stream at beat 12, then a fresh matrix starts at beat 0
        or0 = 1'b1;
        set_a0(0); cm0 = 1'b0; iv0 = 1'b1;
        @(negedge clk);
        iv0 = 1'b0;
        for (int k = 0; k < 12; k++)
            @(negedge clk);
        chk("t6_beat12", 64'(c0[0]), 64'h12);
        reset_n = 1'b0;
        iv0 = 1'b1;
        #1;
        chk("t6_valid_low", 64'(ov0),  64'd0);
        chk("t6_cnt_clear", 64'(cnt0), 64'd0);
        chk("t6_last_low",  64'(ol0),  64'd0);
        chk("t6_c_zero",    64'(c0[0]), 64'd0);
        chk("t6_ready",     64'(ird0), 64'd1);
        @(negedge clk);
        @(negedge clk);
        chk("t6_ignored_ovf", 64'(ovf0), 64'd0);
        chk("t6_ignored_cnt", 64'(cnt0), 64'd0);
        chk("t6_ignored_vld", 64'(ov0),  64'd0);
        iv0 = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        chk("t6_post_idle", 64'(ov0), 64'd0);
        set_a0(32'h500); cm0 = 1'b0; iv0 = 1'b1;
        @(negedge clk);
        drain0(30, 32'h500, 1'b0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
